mmio_uart_tx: RTL

Memory-mapped UART transmitter acting as a responder on the CPU data-memory bus (12-bit address, 16-bit data, separate read/write strobes). It sits beside data RAM in the computer top; the top decodes nothing, and the block matches its own base address. The CPU writes bytes into a TX FIFO, and an 8N1 serialiser shifts them out on a single line at a programmable baud divisor.

---
 rtl/mmio_uart_tx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, status/divisor registers, serialiser.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx #(
  parameter logic [11:0] BASE_ADDR   = 12'hF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [15:0] data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [15:0] data_out,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [15:0]   r_div, r_baud, r_data_out;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_tx;

  logic          w_sel, w_wr, w_rd;
  logic [1:0]    w_off;
  logic          w_full, w_empty, w_push_req, w_push, w_pop;
  logic          w_bit_end, w_busy, w_tx_next, w_par_present;
  logic [7:0]    w_head;
  logic [15:0]   w_status;

  assign w_off      = address[1:0];
  assign w_sel      = (address[11:2] == BASE_ADDR[11:2]);
  assign w_wr       = w_sel & write_enable;
  assign w_rd       = w_sel & read_enable & ~write_enable;

  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push_req = w_wr && (w_off == 2'd0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_head     = r_mem[r_rptr];
  assign w_bit_end  = (r_baud == '0);
  assign w_busy     = (r_state != S_IDLE) || !w_empty;

`ifdef MMIO_UART_PARITY_EN
  logic r_par;
  assign w_par_present = 1'b1;
`else
  assign w_par_present = 1'b0;
`endif

  assign w_status = {8'(r_count), 3'b000, w_par_present, r_ovf, w_empty, w_full, w_busy};
  assign data_out = r_data_out;
  assign tx       = r_tx;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_div      <= DEFAULT_DIV;
      r_data_out <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_wr && (w_off == 2'd1) && data_in[3]) r_ovf <= 1'b0;
      if (w_push_req && w_full && !w_pop)        r_ovf <= 1'b1;
      if (w_wr && (w_off == 2'd2))               r_div <= data_in;
      if (w_rd) begin
        case (w_off)
          2'd1:    r_data_out <= w_status;
          2'd2:    r_data_out <= r_div;
          default: r_data_out <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_tx_next = 1'b0;
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_tx_next = r_shift[0];
`ifdef MMIO_UART_PARITY_EN
        if (w_bit_end && (r_bitcnt == 3'd7)) w_state_next = S_PARITY;
`else
        if (w_bit_end && (r_bitcnt == 3'd7)) w_state_next = S_STOP;
`endif
      end
      S_PARITY: begin
`ifdef MMIO_UART_PARITY_EN
        w_tx_next = r_par;
`endif
        if (w_bit_end) w_state_next = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next frame when more data is waiting.
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_baud   <= '0;
`ifdef MMIO_UART_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_tx <= w_tx_next;
      if (w_pop) begin
        r_shift  <= w_head;
        r_bitcnt <= '0;
        r_baud   <= r_div;
`ifdef MMIO_UART_PARITY_EN
        r_par    <= ^w_head;
`endif
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_baud <= r_div;
          if (r_state == S_DATA) begin
            r_shift  <= r_shift >> 1;
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end else begin
          r_baud <= r_baud - 1'b1;
        end
      end
    end
  end

endmodule
